// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, ALU codes, FSM/class enums and control word for control_sequencer
package cu_pkg;
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5, OP_OR = 5'd6, OP_MUL = 5'd14, OP_DIV = 5'd15, OP_NEG = 5'd17;
  localparam logic [4:0] OP_NOT = 5'd18, OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22;
  localparam logic [4:0] OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd3, ALU_INCPC = 5'd19;
  typedef enum logic [2:0] {S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_EXEC, S_HALT, S_TRAP} state_t;
  typedef enum logic [3:0] {
    CL_NONE, CL_LD, CL_LDI, CL_ST, CL_ALU3, CL_MULDIV, CL_UNARY,
    CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO
  } cls_t;
  typedef struct packed {
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic y_in, z_in, zhigh_out, zlow_out, hi_in, hi_out, lo_in, lo_out, c_out;
    logic pc_in, pc_out, pc_inc, ir_in, mar_in, mdr_in, mdr_out;
    logic mem_read, mem_write, con_in, inport_out, outport_in;
    logic run, illegal;
    logic [4:0] alu_op;
  } cw_t;
  // nop, halt and undefined opcodes all map to CL_NONE; the FSM separates them
  function automatic cls_t op_class(input logic [4:0] op);
    case (op)
      OP_LD: return CL_LD;
      OP_LDI: return CL_LDI;
      OP_ST: return CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CL_ALU3;
      OP_MUL, OP_DIV: return CL_MULDIV;
      OP_NEG, OP_NOT: return CL_UNARY;
      OP_BR: return CL_BR;
      OP_JR: return CL_JR;
      OP_JAL: return CL_JAL;
      OP_IN: return CL_IN;
      OP_OUT: return CL_OUT;
      OP_MFHI: return CL_MFHI;
      OP_MFLO: return CL_MFLO;
      default: return CL_NONE;
    endcase
  endfunction
  function automatic logic [2:0] last_step(input cls_t c);
    case (c)
      CL_LD: return 3'd7;
      CL_ST, CL_MULDIV, CL_BR: return 3'd6;
      CL_LDI, CL_ALU3: return 3'd5;
      CL_UNARY, CL_JAL: return 3'd4;
      default: return 3'd3;
    endcase
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/status inputs and datapath enables of the sequencer
interface control_sequencer_if #(parameter int IR_W = 32, parameter int ALU_OP_W = 5) ();
  logic [IR_W-1:0] ir;
  logic con_ff, mem_ready;
  logic gra, grb, grc, r_in, r_out, ba_out;
  logic y_in, z_in, zhigh_out, zlow_out, hi_in, hi_out, lo_in, lo_out, c_out;
  logic pc_in, pc_out, pc_inc, ir_in, mar_in, mdr_in, mdr_out;
  logic mem_read, mem_write, con_in, inport_out, outport_in;
  logic [ALU_OP_W-1:0] alu_op;
  logic run, illegal;
  modport master (
    input ir, con_ff, mem_ready,
    output gra, grb, grc, r_in, r_out, ba_out, y_in, z_in, zhigh_out, zlow_out, hi_in, hi_out,
      lo_in, lo_out, c_out, pc_in, pc_out, pc_inc, ir_in, mar_in, mdr_in, mdr_out,
      mem_read, mem_write, con_in, inport_out, outport_in, alu_op, run, illegal
  );
  modport slave (
    output ir, con_ff, mem_ready,
    input gra, grb, grc, r_in, r_out, ba_out, y_in, z_in, zhigh_out, zlow_out, hi_in, hi_out,
      lo_in, lo_out, c_out, pc_in, pc_out, pc_inc, ir_in, mar_in, mdr_in, mdr_out,
      mem_read, mem_write, con_in, inport_out, outport_in, alu_op, run, illegal
  );
endinterface

// File: rtl/cu_step_decode.sv
// cu_step_decode: combinational control word for the current state/class/step
module cu_step_decode
  import cu_pkg::*;
(
  input  state_t     i_state,
  input  cls_t       i_cls,
  input  logic [2:0] i_step,
  input  logic [4:0] i_op,
  input  logic       i_con_ff,
  output cw_t        o_cw
);
  // only br T6 looks at an input (con_ff gates pc_in); everything else is pure Moore
  always_comb begin
    o_cw = '0;
    o_cw.run = !(i_state inside {S_RESET, S_HALT, S_TRAP});
    o_cw.illegal = i_state == S_TRAP;
    case (i_state)
      S_FETCH0: begin
        {o_cw.pc_out, o_cw.mar_in, o_cw.pc_inc, o_cw.z_in} = 4'hf;
        o_cw.alu_op = ALU_INCPC;
      end
      S_FETCH1: {o_cw.zlow_out, o_cw.pc_in, o_cw.mem_read, o_cw.mdr_in} = 4'hf;
      S_FETCH2: {o_cw.mdr_out, o_cw.ir_in} = 2'b11;
      S_EXEC: case (i_cls)
        CL_LD, CL_LDI, CL_ST: case (i_step)
          3'd3: {o_cw.grb, o_cw.ba_out, o_cw.r_out, o_cw.y_in} = 4'hf;
          3'd4: begin {o_cw.c_out, o_cw.z_in} = 2'b11; o_cw.alu_op = ALU_ADD; end
          3'd5: if (i_cls == CL_LDI) {o_cw.zlow_out, o_cw.gra, o_cw.r_in} = 3'b111;
                else {o_cw.zlow_out, o_cw.mar_in} = 2'b11;
          3'd6: if (i_cls == CL_ST) {o_cw.gra, o_cw.r_out, o_cw.mdr_in, o_cw.mem_write} = 4'hf;
                else {o_cw.mem_read, o_cw.mdr_in} = 2'b11;
          3'd7: {o_cw.mdr_out, o_cw.gra, o_cw.r_in} = 3'b111;
          default: ;
        endcase
        CL_ALU3: case (i_step)
          3'd3: {o_cw.grb, o_cw.r_out, o_cw.y_in} = 3'b111;
          3'd4: begin {o_cw.grc, o_cw.r_out, o_cw.z_in} = 3'b111; o_cw.alu_op = i_op; end
          3'd5: {o_cw.zlow_out, o_cw.gra, o_cw.r_in} = 3'b111;
          default: ;
        endcase
        CL_MULDIV: case (i_step)
          3'd3: {o_cw.gra, o_cw.r_out, o_cw.y_in} = 3'b111;
          3'd4: begin {o_cw.grb, o_cw.r_out, o_cw.z_in} = 3'b111; o_cw.alu_op = i_op; end
          3'd5: {o_cw.zlow_out, o_cw.lo_in} = 2'b11;
          3'd6: {o_cw.zhigh_out, o_cw.hi_in} = 2'b11;
          default: ;
        endcase
        CL_UNARY: case (i_step)
          3'd3: begin {o_cw.grb, o_cw.r_out, o_cw.z_in} = 3'b111; o_cw.alu_op = i_op; end
          3'd4: {o_cw.zlow_out, o_cw.gra, o_cw.r_in} = 3'b111;
          default: ;
        endcase
        CL_BR: case (i_step)
          3'd3: {o_cw.gra, o_cw.r_out, o_cw.con_in} = 3'b111;
          3'd4: {o_cw.pc_out, o_cw.y_in} = 2'b11;
          3'd5: begin {o_cw.c_out, o_cw.z_in} = 2'b11; o_cw.alu_op = ALU_ADD; end
          3'd6: begin o_cw.zlow_out = 1'b1; o_cw.pc_in = i_con_ff; end
          default: ;
        endcase
        CL_JAL: if (i_step == 3'd3) {o_cw.pc_out, o_cw.grb, o_cw.r_in} = 3'b111;
                else {o_cw.gra, o_cw.r_out, o_cw.pc_in} = 3'b111;
        CL_JR: {o_cw.gra, o_cw.r_out, o_cw.pc_in} = 3'b111;
        CL_IN: {o_cw.inport_out, o_cw.gra, o_cw.r_in} = 3'b111;
        CL_OUT: {o_cw.gra, o_cw.r_out, o_cw.outport_in} = 3'b111;
        CL_MFHI: {o_cw.hi_out, o_cw.gra, o_cw.r_in} = 3'b111;
        CL_MFLO: {o_cw.lo_out, o_cw.gra, o_cw.r_in} = 3'b111;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle CPU control FSM (fetch, execute, HALT, TRAP).
// Define CU_MEM_HANDSHAKE_EN to stall memory steps until mem_ready is sampled high.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int OPC_W    = 5,
  parameter int IR_W     = 32,
  parameter int ALU_OP_W = 5
) (
  input logic clk,
  input logic clr,
  control_sequencer_if.master bus
);
  state_t     r_state;
  cls_t       r_cls;
  logic [2:0] r_step;
  logic [4:0] r_op;
  logic [4:0] w_opc;
  cls_t       w_cls;
  logic       w_stall;
  cw_t        w_cw;
  assign w_opc = 5'(bus.ir[IR_W-1 -: OPC_W]);
  assign w_cls = op_class(w_opc);
`ifdef CU_MEM_HANDSHAKE_EN
  logic w_mem_step;
  assign w_mem_step = r_state == S_FETCH1 ||
                      (r_state == S_EXEC && r_step == 3'd6 && (r_cls == CL_LD || r_cls == CL_ST));
  assign w_stall = w_mem_step && !bus.mem_ready;
`else
  assign w_stall = 1'b0;
`endif
  // state, step and class; ir is captured only on the FETCH2 exit edge
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      r_state <= S_RESET;
      r_step <= '0;
      r_cls <= CL_NONE;
      r_op <= '0;
    end else if (!w_stall) case (r_state)
      S_RESET: r_state <= S_FETCH0;
      S_FETCH0: r_state <= S_FETCH1;
      S_FETCH1: r_state <= S_FETCH2;
      S_FETCH2: begin
        r_state <= w_opc == OP_NOP ? S_FETCH0 : w_opc == OP_HALT ? S_HALT :
                   w_cls == CL_NONE ? S_TRAP : S_EXEC;
        r_step <= 3'd3;
        r_cls <= w_cls;
        r_op <= w_opc;
      end
      S_EXEC: begin
        r_state <= r_step == last_step(r_cls) ? S_FETCH0 : S_EXEC;
        r_step <= r_step + 3'd1;
      end
      default: r_state <= r_state;
    endcase
  cu_step_decode u_dec (
    .i_state(r_state), .i_cls(r_cls), .i_step(r_step), .i_op(r_op),
    .i_con_ff(bus.con_ff), .o_cw(w_cw)
  );
  assign {bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out, bus.ba_out} =
         {w_cw.gra, w_cw.grb, w_cw.grc, w_cw.r_in, w_cw.r_out, w_cw.ba_out};
  assign {bus.y_in, bus.z_in, bus.zhigh_out, bus.zlow_out, bus.hi_in, bus.hi_out, bus.lo_in, bus.lo_out, bus.c_out} =
         {w_cw.y_in, w_cw.z_in, w_cw.zhigh_out, w_cw.zlow_out, w_cw.hi_in, w_cw.hi_out, w_cw.lo_in, w_cw.lo_out, w_cw.c_out};
  assign {bus.pc_in, bus.pc_out, bus.pc_inc, bus.ir_in, bus.mar_in, bus.mdr_in, bus.mdr_out} =
         {w_cw.pc_in, w_cw.pc_out, w_cw.pc_inc, w_cw.ir_in, w_cw.mar_in, w_cw.mdr_in, w_cw.mdr_out};
  assign {bus.mem_read, bus.mem_write, bus.con_in, bus.inport_out, bus.outport_in, bus.run, bus.illegal} =
         {w_cw.mem_read, w_cw.mem_write, w_cw.con_in, w_cw.inport_out, w_cw.outport_in, w_cw.run, w_cw.illegal};
  assign bus.alu_op = ALU_OP_W'(w_cw.alu_op);
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; expected control words queued per cycle, checked on negedge
module tb_control_sequencer;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;
  control_sequencer_if #(.IR_W(32), .ALU_OP_W(5)) bus ();
  control_sequencer #(.OPC_W(5), .IR_W(32), .ALU_OP_W(5)) dut (.clk(clk), .clr(clr), .bus(bus));
  localparam logic [26:0] GRA = 27'd1 << 0, GRB = 27'd1 << 1, GRC = 27'd1 << 2, R_IN = 27'd1 << 3;
  localparam logic [26:0] R_OUT = 27'd1 << 4, BA_OUT = 27'd1 << 5, Y_IN = 27'd1 << 6, Z_IN = 27'd1 << 7;
  localparam logic [26:0] ZHIGH_OUT = 27'd1 << 8, ZLOW_OUT = 27'd1 << 9, HI_IN = 27'd1 << 10, HI_OUT = 27'd1 << 11;
  localparam logic [26:0] LO_IN = 27'd1 << 12, LO_OUT = 27'd1 << 13, C_OUT = 27'd1 << 14, PC_IN = 27'd1 << 15;
  localparam logic [26:0] PC_OUT = 27'd1 << 16, PC_INC = 27'd1 << 17, IR_IN = 27'd1 << 18, MAR_IN = 27'd1 << 19;
  localparam logic [26:0] MDR_IN = 27'd1 << 20, MDR_OUT = 27'd1 << 21, MEM_READ = 27'd1 << 22, MEM_WRITE = 27'd1 << 23;
  localparam logic [26:0] CON_IN = 27'd1 << 24, INPORT_OUT = 27'd1 << 25, OUTPORT_IN = 27'd1 << 26;
  logic [33:0] q[$];
  string qn[$];
  int total = 0, bad = 0;
  logic [26:0] act_en;
  logic [33:0] act, want;
  string nm;
  assign act_en = {bus.outport_in, bus.inport_out, bus.con_in, bus.mem_write, bus.mem_read, bus.mdr_out,
                   bus.mdr_in, bus.mar_in, bus.ir_in, bus.pc_inc, bus.pc_out, bus.pc_in, bus.c_out,
                   bus.lo_out, bus.lo_in, bus.hi_out, bus.hi_in, bus.zlow_out, bus.zhigh_out, bus.z_in,
                   bus.y_in, bus.ba_out, bus.r_out, bus.r_in, bus.grc, bus.grb, bus.gra};
  always @(negedge clk)
    if (q.size() != 0) begin
      want = q.pop_front();
      nm = qn.pop_front();
      act = {act_en, bus.alu_op, bus.run, bus.illegal};
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL %s: got en=%h alu=%0d run=%b ill=%b, want en=%h alu=%0d run=%b ill=%b",
                 nm, act[33:7], act[6:2], act[1], act[0], want[33:7], want[6:2], want[1], want[0]);
      end
    end
  task automatic px(input string n, input logic [26:0] en, input logic [4:0] alu = 5'd0,
                    input logic run = 1'b1, input logic ill = 1'b0);
    q.push_back({en, alu, run, ill});
    qn.push_back(n);
  endtask
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic fetch(input logic [4:0] opc, input logic con);
    bus.ir = {opc, 27'd0};
    bus.con_ff = con;
    px("fetch0", PC_OUT | MAR_IN | PC_INC | Z_IN, 5'd19);
    px("fetch1", ZLOW_OUT | PC_IN | MEM_READ | MDR_IN);
    px("fetch2", MDR_OUT | IR_IN);
  endtask
  task automatic rst_pulse(input string n);
    clr = 1'b0;
    px(n, '0, 5'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    clr = 1'b0;
    bus.ir = '0;
    bus.con_ff = 1'b0;
    bus.mem_ready = 1'b1;
    #1 rst_pulse("reset");
    fetch(5'b00000, 1'b0);
    px("ld_t3", GRB | BA_OUT | R_OUT | Y_IN);
    px("ld_t4", C_OUT | Z_IN, 5'd3);
    cyc(5);
    rst_pulse("abort_ld_t5");
    fetch(5'b00000, 1'b0);
    px("ld_t3", GRB | BA_OUT | R_OUT | Y_IN);
    px("ld_t4", C_OUT | Z_IN, 5'd3);
    px("ld_t5", ZLOW_OUT | MAR_IN);
    px("ld_t6", MEM_READ | MDR_IN);
    px("ld_t7", MDR_OUT | GRA | R_IN);
    cyc(4);
    bus.ir = {5'b00011, 27'd0};
    cyc(4);
    fetch(5'b00010, 1'b0);
    px("st_t3", GRB | BA_OUT | R_OUT | Y_IN);
    px("st_t4", C_OUT | Z_IN, 5'd3);
    px("st_t5", ZLOW_OUT | MAR_IN);
    px("st_t6", GRA | R_OUT | MDR_IN | MEM_WRITE);
    cyc(7);
    fetch(5'b00001, 1'b0);
    px("ldi_t3", GRB | BA_OUT | R_OUT | Y_IN);
    px("ldi_t4", C_OUT | Z_IN, 5'd3);
    px("ldi_t5", ZLOW_OUT | GRA | R_IN);
    cyc(6);
    fetch(5'b00100, 1'b0);
    px("sub_t3", GRB | R_OUT | Y_IN);
    px("sub_t4", GRC | R_OUT | Z_IN, 5'd4);
    px("sub_t5", ZLOW_OUT | GRA | R_IN);
    cyc(6);
    fetch(5'b01111, 1'b0);
    px("div_t3", GRA | R_OUT | Y_IN);
    px("div_t4", GRB | R_OUT | Z_IN, 5'd15);
    px("div_t5", ZLOW_OUT | LO_IN);
    px("div_t6", ZHIGH_OUT | HI_IN);
    cyc(7);
    fetch(5'b10010, 1'b0);
    px("not_t3", GRB | R_OUT | Z_IN, 5'd18);
    px("not_t4", ZLOW_OUT | GRA | R_IN);
    cyc(5);
    for (int c = 0; c < 2; c++) begin
      fetch(5'b10011, c[0]);
      px("br_t3", GRA | R_OUT | CON_IN);
      px("br_t4", PC_OUT | Y_IN);
      px("br_t5", C_OUT | Z_IN, 5'd3);
      px(c == 0 ? "br_t6_con0" : "br_t6_con1", c == 0 ? ZLOW_OUT : ZLOW_OUT | PC_IN);
      cyc(7);
    end
    fetch(5'b10101, 1'b0);
    px("jal_t3", PC_OUT | GRB | R_IN);
    px("jal_t4", GRA | R_OUT | PC_IN);
    cyc(5);
    fetch(5'b10100, 1'b0);
    px("jr_t3", GRA | R_OUT | PC_IN);
    cyc(4);
    fetch(5'b11000, 1'b0);
    px("mfhi_t3", HI_OUT | GRA | R_IN);
    cyc(4);
    fetch(5'b10111, 1'b0);
    px("out_t3", GRA | R_OUT | OUTPORT_IN);
    cyc(4);
    bus.ir = {5'b11010, 27'd0};
    px("nop_f0", PC_OUT | MAR_IN | PC_INC | Z_IN, 5'd19);
`ifdef CU_MEM_HANDSHAKE_EN
    repeat (4) px("nop_f1_held", ZLOW_OUT | PC_IN | MEM_READ | MDR_IN);
    px("nop_f2", MDR_OUT | IR_IN);
    bus.mem_ready = 1'b0;
    cyc(4);
    bus.mem_ready = 1'b1;
    cyc(2);
`else
    px("nop_f1", ZLOW_OUT | PC_IN | MEM_READ | MDR_IN);
    px("nop_f2", MDR_OUT | IR_IN);
    bus.mem_ready = 1'b0;
    cyc(2);
    bus.mem_ready = 1'b1;
    cyc(1);
`endif
    fetch(5'b11111, 1'b0);
    repeat (3) px("trap", '0, 5'd0, 1'b0, 1'b1);
    cyc(6);
    rst_pulse("trap_clr");
    fetch(5'b11011, 1'b0);
    repeat (3) px("halt", '0, 5'd0, 1'b0, 1'b0);
    cyc(6);
    for (int w = 0; w < 20 && q.size() != 0; w++) begin @(negedge clk); #1; end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
